// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to DMA_REG halts the CPU and copies one 256-byte page
// to OAM_DATA through the shared system bus, one read/write pair per two cycles.
module oam_dma #(
    parameter logic [15:0] DMA_REG  = 16'h4014,
    parameter logic [15:0] OAM_DATA = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_we,
    input  logic [7:0]  bus_d_in,
    output logic        cpu_rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_we,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        rdy_q, busy_q, done_q, done_d;

    // Next-state logic. Only IDLE decodes the CPU bus, so DMA_REG writes during a
    // transfer leave page and idx untouched.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_we && cpu_a == DMA_REG) begin
                    page_d  = cpu_d;
                    idx_d   = 8'd0;
                    state_d = HALT;
                end
            end
            HALT: begin
                // The CPU may finish pending write cycles; READ must land on an even cycle,
                // i.e. directly after an odd HALT cycle, otherwise via one ALIGN cycle.
                if (!cpu_we) begin
                    state_d = parity_q ? READ : ALIGN;
                end
            end
            ALIGN: state_d = READ;
            READ: begin
                byte_d  = bus_d_in;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            byte_q   <= 8'd0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            rdy_q    <= (state_d == IDLE);
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
        end
    end

    // Bus ownership follows the registered state; reset hands the bus back to the CPU at once.
    always_comb begin
        bus_a     = cpu_a;
        bus_d_out = cpu_d;
        bus_we    = cpu_we;
        if (rst_n) begin
            case (state_q)
                READ: begin
                    bus_a     = {page_q, idx_q};
                    bus_d_out = byte_q;
                    bus_we    = 1'b0;
                end
                WRITE: begin
                    bus_a     = OAM_DATA;
                    bus_d_out = byte_q;
                    bus_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdy  = rdy_q;
    assign dma_busy = busy_q;
    assign dma_done = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a cycle-indexed schedule model predicts every output
// each cycle, and directed scenarios pin latency, ordering, abort and wrap behaviour.
module tb_oam_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_d = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  bus_d_in;
    logic        cpu_rdy, bus_we, dma_busy, dma_done;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_out;

    oam_dma dut (
        .clk(clk), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we),
        .bus_d_in(bus_d_in), .cpu_rdy(cpu_rdy), .bus_a(bus_a), .bus_d_out(bus_d_out),
        .bus_we(bus_we), .dma_busy(dma_busy), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    assign bus_d_in = mem[bus_a];

    int checks = 0;
    int failures = 0;

    // Model: cyc counts cycles since reset release (its LSB is the cycle parity). A transfer
    // is busy from the cycle after the trigger; once the CPU stops writing, the 512-cycle
    // read/write sequence starts on the next even cycle.
    int         cyc = 0;
    bit         m_busy = 0, m_dropped = 0, m_done = 0, check_en = 0;
    int         rw_start = 0;
    logic [7:0] m_page = 8'h00;

    int         abs_cyc = 0, first_busy_cyc = 0, done_cyc = 0;
    bit         prev_busy = 0, done_seen = 0;
    logic [7:0]  wr_q[$];
    logic [15:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, abs_cyc);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] x;
        x = 16'($urandom);
        if (x == 16'h4014 || x == 16'h2004) x = 16'h1234;
        return x;
    endfunction

    task automatic cycle();
        logic [15:0] ea, a;
        logic [7:0]  ed, d;
        logic        ew, w, r;
        bit          chk_d, rd_cyc;
        int          k;
        @(negedge clk);
        ea = cpu_a; ed = cpu_d; ew = cpu_we; chk_d = 1; rd_cyc = 0;
        if (rst_n && m_busy && m_dropped && cyc >= rw_start) begin
            k = cyc - rw_start;
            if (k % 2 == 0) begin
                ea = {m_page, 8'(k / 2)}; ew = 1'b0; chk_d = 0; rd_cyc = 1;
            end else begin
                ea = 16'h2004; ew = 1'b1; ed = mem[{m_page, 8'(k / 2)}];
            end
        end
        if (check_en) begin
            check("cpu_rdy", 32'(cpu_rdy), 32'(!m_busy));
            check("dma_busy", 32'(dma_busy), 32'(m_busy));
            check("dma_done", 32'(dma_done), 32'(m_done));
            check("bus_a", 32'(bus_a), 32'(ea));
            check("bus_we", 32'(bus_we), 32'(ew));
            if (chk_d) check("bus_d_out", 32'(bus_d_out), 32'(ed));
            if (dma_busy && bus_we && bus_a == 16'h2004) wr_q.push_back(bus_d_out);
            if (rd_cyc) rd_q.push_back(bus_a);
            if (dma_busy && !prev_busy) first_busy_cyc = abs_cyc;
            if (dma_done) begin done_cyc = abs_cyc; done_seen = 1; end
            prev_busy = dma_busy;
        end
        a = cpu_a; d = cpu_d; w = cpu_we; r = rst_n;
        @(posedge clk);
        #1;
        if (!r) begin
            cyc = 0; m_busy = 0; m_done = 0; m_dropped = 0; check_en = 1;
        end else begin
            m_done = m_busy && m_dropped && (cyc == rw_start + 511);
            if (m_done) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (w && a == 16'h4014) begin
                    m_busy = 1; m_page = d; m_dropped = 0;
                end
            end else if (!m_dropped && !w) begin
                m_dropped = 1;
                rw_start = ((cyc + 1) % 2 == 0) ? cyc + 1 : cyc + 2;
            end
            cyc++;
        end
        abs_cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_a = rand_addr(); cpu_d = 8'($urandom); cpu_we = 1'($urandom_range(0, 1));
            cycle();
        end
    endtask

    task automatic wait_parity(input int p);
        while (cyc % 2 != p) begin
            cpu_a = rand_addr(); cpu_d = 8'($urandom); cpu_we = 1'b0;
            cycle();
        end
    endtask

    task automatic trigger(input logic [7:0] page, input int extra_we);
        wr_q.delete(); rd_q.delete(); done_seen = 0;
        cpu_a = 16'h4014; cpu_d = page; cpu_we = 1'b1;
        cycle();
        for (int i = 0; i < extra_we; i++) begin
            cpu_a = rand_addr(); cpu_d = 8'($urandom); cpu_we = 1'b1;
            cycle();
        end
    endtask

    // Runs until dma_done is seen; optionally injects a DMA_REG write or a reset at a given
    // step k of the read/write sequence (k even = read of idx k/2, k odd = its write).
    task automatic run_xfer(input int bound, input int inj_k, input int rst_k);
        for (int i = 0; i < bound; i++) begin
            cpu_a = rand_addr(); cpu_d = 8'($urandom); cpu_we = 1'b0;
            if (m_busy && m_dropped && inj_k >= 0 && cyc == rw_start + inj_k) begin
                cpu_a = 16'h4014; cpu_d = 8'h05; cpu_we = 1'b1;
            end
            if (m_busy && m_dropped && rst_k >= 0 && cyc == rw_start + rst_k) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
                return;
            end
            cycle();
            if (done_seen) break;
        end
        check("xfer_done_seen", 32'(done_seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [7:0] p;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) cycle();
        rst_n = 1'b1;
        cpu_a = 16'hBEEF; cpu_d = 8'h5A; cpu_we = 1'b1;
        #3;
        check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_dma_busy", 32'(dma_busy), 32'd0);
        check("rst_dma_done", 32'(dma_done), 32'd0);
        check("rst_bus_a", 32'(bus_a), 32'h0000BEEF);
        check("rst_bus_we", 32'(bus_we), 32'd1);
        check("rst_bus_d_out", 32'(bus_d_out), 32'h5A);
        idle(20);

        // Even-parity trigger: HALT is odd, no ALIGN.
        wait_parity(0);
        trigger(8'h02, 0);
        run_xfer(600, -1, -1);
        check("t034_latency", 32'(done_cyc - first_busy_cyc), 32'd513);
        check("t034_writes", 32'(wr_q.size()), 32'd256);
        check("t034_first_rd", 32'(rd_q[0]), 32'h0200);
        check("t034_last_rd", 32'(rd_q[255]), 32'h02FF);
        bad = 0;
        for (int i = 0; i < 256 && i < wr_q.size(); i++) if (wr_q[i] !== mem[16'h0200 + i]) bad++;
        check("t034_data", 32'(bad), 32'd0);
        #3 check("t034_rdy_after", 32'(cpu_rdy), 32'd1);
        idle(7);

        // Odd-parity trigger: HALT is even, ALIGN adds one cycle.
        p = 8'($urandom);
        wait_parity(1);
        trigger(p, 0);
        run_xfer(600, -1, -1);
        check("t035_latency", 32'(done_cyc - first_busy_cyc), 32'd514);
        check("t035_first_rd", 32'(rd_q[0]), 32'({p, 8'h00}));
        idle(5);

        // Two extra CPU write cycles stretch HALT by two cycles.
        p = 8'($urandom);
        wait_parity(0);
        trigger(p, 2);
        run_xfer(600, -1, -1);
        check("t036_latency", 32'(done_cyc - first_busy_cyc), 32'(1 + 2 + 0 + 512));
        check("t036_writes", 32'(wr_q.size()), 32'd256);
        idle(4);

        // DMA_REG write of 05 during byte 100 of a page-03 transfer is ignored.
        trigger(8'h03, 0);
        run_xfer(600, 200, -1);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i][15:8] !== 8'h03) bad++;
        check("t037_foreign_page", 32'(bad), 32'd0);
        check("t037_reads", 32'(rd_q.size()), 32'd256);
        idle(6);

        // Reset during the write of byte 37 abandons the transfer.
        trigger(8'($urandom), 0);
        run_xfer(600, -1, 2 * 37 + 1);
        cpu_a = 16'h0123; cpu_d = 8'h77; cpu_we = 1'b1;
        #3;
        check("t038_busy", 32'(dma_busy), 32'd0);
        check("t038_rdy", 32'(cpu_rdy), 32'd1);
        check("t038_bus_a", 32'(bus_a), 32'h0123);
        check("t038_bus_d", 32'(bus_d_out), 32'h77);
        check("t038_writes", 32'(wr_q.size()), 32'd37);
        cycle();
        idle(30);
        check("t038_no_more_writes", 32'(wr_q.size()), 32'd37);

        // Page FF with an idx^A5 pattern, then a new trigger right after dma_done.
        for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;
        wait_parity(int'($urandom_range(0, 1)));
        trigger(8'hFF, 0);
        run_xfer(600, -1, -1);
        check("t039_writes", 32'(wr_q.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < 256 && i < wr_q.size(); i++) if (wr_q[i] !== (8'(i) ^ 8'hA5)) bad++;
        check("t039_pattern", 32'(bad), 32'd0);
        check("t039_last_rd", 32'(rd_q[255]), 32'hFFFF);
        trigger(8'h01, 0);
        run_xfer(600, -1, -1);
        check("t030_first_rd", 32'(rd_q[0]), 32'h0100);
        check("t030_writes", 32'(wr_q.size()), 32'd256);

        // Randomized transfers: random gap, page and HALT stretch.
        for (int n = 0; n < 3; n++) begin
            idle(int'($urandom_range(1, 10)));
            trigger(8'($urandom), int'($urandom_range(0, 3)));
            run_xfer(700, -1, -1);
            check("rand_writes", 32'(wr_q.size()), 32'd256);
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
